round_sequencer: RTL

Game-flow controller for the reflex game. It drives the per-round judge with the `level` window, a pseudo-random `action` code and the tick `count`, and reads back the judge's cumulative `wrong_time`. Each game runs as a fixed number of rounds, each a rest gap followed by a response window. It ends early when the error budget is exhausted. It sits between the button/start front end and the judge, and feeds the display/score logic.

---
 rtl/round_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/round_sequencer.sv
// Reflex game flow controller: rest gap, response window and round counting.
// Each game ends early once the judge's error count reaches the budget.
module round_sequencer #(
  parameter int CLK_PER_TICK     = 5_000_000,
  parameter int TICKS_PER_WINDOW = 30,
  parameter int GAP_TICKS        = 10,
  parameter int NUM_ROUNDS       = 16,
  parameter int MAX_WRONG        = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] judge_wrong,
  output logic       level,
  output logic [3:0] action,
  output logic [7:0] count,
  output logic [7:0] round,
  output logic [7:0] errors,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [1:0] {
    IDLE, GAP, WINDOW, DONE
  } state_t;

  state_t      state;
  logic [31:0] presc;
  logic [31:0] gap_cnt;
  logic [7:0]  lfsr;
  logic [7:0]  base;

  logic       tick;
  logic [7:0] diff;
  logic [7:0] lfsr_next;

  assign tick      = (presc == 32'(CLK_PER_TICK - 1));
  assign diff      = judge_wrong - base;
  assign lfsr_next = {lfsr[6:0],
                      lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      gap_cnt   <= '0;
      lfsr      <= LFSR_SEED;
      base      <= '0;
      level     <= 1'b0;
      action    <= '0;
      count     <= '0;
      round     <= '0;
      errors    <= '0;
      game_over <= 1'b0;
      win       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= GAP;
            base      <= judge_wrong;
            presc     <= '0;
            gap_cnt   <= '0;
            level     <= 1'b0;
            count     <= '0;
            round     <= '0;
            errors    <= '0;
            game_over <= 1'b0;
            win       <= 1'b0;
          end
        end
        GAP, WINDOW: begin
          errors <= diff;
          // error budget outranks window expiry and the win check
          if (diff >= 8'(MAX_WRONG)) begin
            state     <= DONE;
            presc     <= '0;
            level     <= 1'b0;
            game_over <= 1'b1;
            win       <= 1'b0;
          end else begin
            presc <= tick ? '0 : presc + 32'd1;
            if (state == GAP) begin
              if (tick) begin
                if (gap_cnt == 32'(GAP_TICKS - 1)) begin
                  state   <= WINDOW;
                  gap_cnt <= '0;
                  lfsr    <= lfsr_next;
                  action  <= {2'b00, lfsr_next[1:0]};
                  round   <= round + 8'd1;
                  count   <= '0;
                  level   <= 1'b1;
                end else begin
                  gap_cnt <= gap_cnt + 32'd1;
                end
              end
            end else if (tick) begin
              if (count == 8'(TICKS_PER_WINDOW - 1)) begin
                level <= 1'b0;
                if (round == 8'(NUM_ROUNDS)) begin
                  state     <= DONE;
                  game_over <= 1'b1;
                  win       <= 1'b1;
                end else begin
                  state <= GAP;
                  count <= '0;
                end
              end else begin
                count <= count + 8'd1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule
